// File: rtl/ddr_pkg.sv
// Shared types and helpers for packing ioctl download words into 64-bit DDR lines.
package ddr_pkg;

  localparam int DDR_DATA_WIDTH = 64;
  localparam int DDR_MASK_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_FINISH
  } ioctl_wr_state_t;

  // Each 16-bit lane owns two adjacent byte enables.
  function automatic logic [DDR_MASK_WIDTH-1:0] lane_mask(input logic [1:0] k);
    lane_mask = 8'b0000_0011 << {k, 1'b0};
  endfunction

endpackage

// File: rtl/ddr_line_buffer.sv
// 64-bit data/byte-mask accumulator for one DDR line; clear beats load beats merge.
module ddr_line_buffer
  import ddr_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      load,
  input  logic                      merge,
  input  logic [1:0]                lane,
  input  logic [15:0]               data,
  output logic [DDR_DATA_WIDTH-1:0] din,
  output logic [DDR_MASK_WIDTH-1:0] mask
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      din  <= '0;
      mask <= '0;
    end else if (load) begin
      // Start a fresh line holding only this word.
      din  <= {48'd0, data} << {lane, 4'b0000};
      mask <= lane_mask(lane);
    end else if (merge) begin
      din[{lane, 4'b0000} +: 16] <= data;
      mask                       <= mask | lane_mask(lane);
    end
  end

endmodule

// File: rtl/ioctl_ddr_writer.sv
// Collects HPS ioctl download words into 8-byte DDR writes and pulses done when the download ends.
module ioctl_ddr_writer
  import ddr_pkg::*;
#(
  parameter int                        ADDR_WIDTH     = 27,
  parameter int                        DDR_ADDR_WIDTH = 32,
  parameter logic [DDR_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [7:0]                INDEX          = 8'd0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ioctl_download,
  input  logic                      ioctl_wr,
  input  logic [7:0]                ioctl_index,
  input  logic [ADDR_WIDTH-1:0]     ioctl_addr,
  input  logic [15:0]               ioctl_dout,
  output logic                      ioctl_waitReq,
  output logic                      ddr_wr,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_addr,
  output logic [DDR_DATA_WIDTH-1:0] ddr_din,
  output logic [DDR_MASK_WIDTH-1:0] ddr_mask,
  output logic [7:0]                ddr_burstLength,
  input  logic                      ddr_waitReq,
  output logic                      done
);

  localparam int TAG_W = ADDR_WIDTH - 3;

  ioctl_wr_state_t state;

  logic             dl_p1;
  logic [TAG_W-1:0] tag;
  logic             flush;
  logic             pend_vld;
  logic [1:0]       pend_lane;
  logic [TAG_W-1:0] pend_tag;
  logic [15:0]      pend_data;

  logic             accept;
  logic             fall;
  logic [TAG_W-1:0] word_tag;
  logic [1:0]       word_lane;
  logic             same_tag;
  logic             full;
  logic             go_write;
  logic             wr_done;
  logic             addr_unused;

  logic                      buf_clear;
  logic                      buf_load;
  logic                      buf_merge;
  logic [1:0]                buf_lane;
  logic [15:0]               buf_data;
  logic [DDR_DATA_WIDTH-1:0] buf_din;
  logic [DDR_MASK_WIDTH-1:0] buf_mask;
  logic [DDR_ADDR_WIDTH-1:0] line_addr;

  assign accept      = ioctl_wr && ioctl_download && (ioctl_index == INDEX);
  assign fall        = dl_p1 && !ioctl_download;
  assign word_tag    = ioctl_addr[ADDR_WIDTH-1:3];
  assign word_lane   = ioctl_addr[2:1];
  assign addr_unused = ioctl_addr[0];
  assign same_tag    = (word_tag == tag);
  assign full        = ((buf_mask | lane_mask(word_lane)) == 8'hFF);
  assign wr_done     = (state == ST_WRITE) && !ddr_waitReq;
  // Modulo 2^DDR_ADDR_WIDTH by construction of the result width.
  assign line_addr   = BASE_ADDR + DDR_ADDR_WIDTH'({tag, 3'b000});

  assign ddr_din         = buf_din;
  assign ddr_mask        = buf_mask;
  assign ddr_burstLength = 8'd1;

  always_comb begin
    buf_clear = 1'b0;
    buf_load  = 1'b0;
    buf_merge = 1'b0;
    buf_lane  = word_lane;
    buf_data  = ioctl_dout;
    go_write  = 1'b0;
    case (state)
      ST_IDLE: buf_load = accept;
      ST_FILL: begin
        buf_merge = accept && same_tag;
        if (accept) go_write = same_tag ? (full || fall || flush) : 1'b1;
        else        go_write = fall || flush;
      end
      ST_WRITE: begin
        if (wr_done) begin
          if (pend_vld) begin
            buf_load = 1'b1;
            buf_lane = pend_lane;
            buf_data = pend_data;
          end else begin
            buf_clear = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  ddr_line_buffer u_line (
    .clock (clock),
    .reset (reset),
    .clear (buf_clear),
    .load  (buf_load),
    .merge (buf_merge),
    .lane  (buf_lane),
    .data  (buf_data),
    .din   (buf_din),
    .mask  (buf_mask)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      dl_p1         <= 1'b0;
      tag           <= '0;
      flush         <= 1'b0;
      pend_vld      <= 1'b0;
      pend_lane     <= '0;
      pend_tag      <= '0;
      pend_data     <= '0;
      ioctl_waitReq <= 1'b0;
      ddr_wr        <= 1'b0;
      ddr_addr      <= '0;
      done          <= 1'b0;
    end else begin
      dl_p1 <= ioctl_download;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tag   <= word_tag;
            flush <= fall;
            state <= ST_FILL;
          end else if (fall) begin
            done  <= 1'b1;
            state <= ST_FINISH;
          end
        end
        ST_FILL: begin
          if (accept && !same_tag) begin
            pend_vld  <= 1'b1;
            pend_lane <= word_lane;
            pend_tag  <= word_tag;
            pend_data <= ioctl_dout;
          end
          if (go_write) begin
            flush         <= flush || fall;
            ddr_addr      <= line_addr;
            ddr_wr        <= 1'b1;
            ioctl_waitReq <= 1'b1;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          // A download end seen while stalled must still produce a flush/done.
          if (fall) flush <= 1'b1;
          if (wr_done) begin
            ddr_wr        <= 1'b0;
            ioctl_waitReq <= 1'b0;
            if (pend_vld) begin
              pend_vld <= 1'b0;
              tag      <= pend_tag;
              state    <= ST_FILL;
            end else if (flush || fall) begin
              flush <= 1'b0;
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          flush <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_ddr_writer.sv
// Directed bench for ioctl_ddr_writer with hand-computed expectations.
module tb_ioctl_ddr_writer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [26:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_waitReq;
  logic        ddr_wr;
  logic [31:0] ddr_addr;
  logic [63:0] ddr_din;
  logic [7:0]  ddr_mask;
  logic [7:0]  ddr_burstLength;
  logic        ddr_waitReq = 1'b0;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  ioctl_ddr_writer dut (
    .clock           (clock),
    .reset           (reset),
    .ioctl_download  (ioctl_download),
    .ioctl_wr        (ioctl_wr),
    .ioctl_index     (ioctl_index),
    .ioctl_addr      (ioctl_addr),
    .ioctl_dout      (ioctl_dout),
    .ioctl_waitReq   (ioctl_waitReq),
    .ddr_wr          (ddr_wr),
    .ddr_addr        (ddr_addr),
    .ddr_din         (ddr_din),
    .ddr_mask        (ddr_mask),
    .ddr_burstLength (ddr_burstLength),
    .ddr_waitReq     (ddr_waitReq),
    .done            (done)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; the HPS never strobes while stalled.
  task automatic word(input logic [26:0] a, input logic [15:0] d);
    chk("no_wr_while_stalled", ioctl_waitReq, 0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_ddr_wr", ddr_wr, 0);
    chk("rst_waitreq", ioctl_waitReq, 0);
    chk("rst_addr", ddr_addr, 0);
    chk("rst_din", ddr_din, 0);
    chk("rst_mask", ddr_mask, 0);
    chk("rst_done", done, 0);
    chk("burst_len", ddr_burstLength, 8'd1);
    reset = 1'b0;
    ioctl_download = 1'b1;
    step();

    // Full line, single write one cycle after the 4th strobe.
    word(27'h0, 16'h1111);
    word(27'h2, 16'h2222);
    word(27'h4, 16'h3333);
    chk("t1_partial_wr", ddr_wr, 0);
    chk("t1_partial_mask", ddr_mask, 8'h3F);
    word(27'h6, 16'h4444);
    chk("t1_wr", ddr_wr, 1);
    chk("t1_addr", ddr_addr, 32'h3000_0000);
    chk("t1_din", ddr_din, 64'h4444_3333_2222_1111);
    chk("t1_mask", ddr_mask, 8'hFF);
    chk("t1_waitreq", ioctl_waitReq, 1);
    step();
    chk("t1_wr_low", ddr_wr, 0);
    chk("t1_waitreq_low", ioctl_waitReq, 0);
    chk("t1_buf_clear", ddr_mask, 8'h00);

    // Tag change pushes a partial line and parks the new word.
    word(27'h8, 16'hAAAA);
    word(27'hA, 16'hBBBB);
    word(27'h20, 16'hCCCC);
    chk("t2_wr", ddr_wr, 1);
    chk("t2_addr", ddr_addr, 32'h3000_0008);
    chk("t2_din", ddr_din, 64'h0000_0000_BBBB_AAAA);
    chk("t2_mask", ddr_mask, 8'h0F);
    step();
    chk("t2_wr_low", ddr_wr, 0);
    chk("t2_pend_din", ddr_din, 64'h0000_0000_0000_CCCC);
    chk("t2_pend_mask", ddr_mask, 8'h03);

    // Complete tag 4 and stall the DDR side for 5 cycles.
    word(27'h22, 16'hDDDD);
    word(27'h24, 16'hEEEE);
    ddr_waitReq = 1'b1;
    word(27'h26, 16'hFFFF);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) ddr_waitReq = 1'b0;
      chk("t3_wr", ddr_wr, 1);
      chk("t3_addr", ddr_addr, 32'h3000_0020);
      chk("t3_din", ddr_din, 64'hFFFF_EEEE_DDDD_CCCC);
      chk("t3_mask", ddr_mask, 8'hFF);
      chk("t3_waitreq", ioctl_waitReq, 1);
      step();
    end
    chk("t3_wr_low", ddr_wr, 0);
    chk("t3_waitreq_low", ioctl_waitReq, 0);

    // Single word then download end: flush, then done.
    word(27'hE, 16'h5A5A);
    chk("t4_nowr", ddr_wr, 0);
    chk("t4_fill_mask", ddr_mask, 8'hC0);
    ioctl_download = 1'b0;
    step();
    chk("t4_wr", ddr_wr, 1);
    chk("t4_addr", ddr_addr, 32'h3000_0008);
    chk("t4_mask", ddr_mask, 8'hC0);
    chk("t4_din", ddr_din, 64'h5A5A_0000_0000_0000);
    chk("t4_done_early", done, 0);
    step();
    chk("t4_wr_low", ddr_wr, 0);
    chk("t4_done", done, 1);
    step();
    chk("t4_done_once", done, 0);

    // Empty download: done only.
    ioctl_download = 1'b1;
    step();
    step();
    ioctl_download = 1'b0;
    step();
    chk("t5_done", done, 1);
    chk("t5_nowr", ddr_wr, 0);
    step();
    chk("t5_done_once", done, 0);
    chk("t5_nowr2", ddr_wr, 0);

    // Foreign index is ignored.
    ioctl_download = 1'b1;
    step();
    ioctl_index = 8'd1;
    word(27'h0, 16'h1234);
    word(27'h2, 16'h5678);
    chk("t6_nowr", ddr_wr, 0);
    chk("t6_mask", ddr_mask, 8'h00);
    chk("t6_din", ddr_din, 64'h0);
    ioctl_index = 8'd0;

    // Reset while stalled in WRITE.
    ddr_waitReq = 1'b1;
    word(27'h0, 16'h0101);
    word(27'h2, 16'h0202);
    word(27'h4, 16'h0303);
    word(27'h6, 16'h0404);
    chk("t7_wr", ddr_wr, 1);
    step();
    reset = 1'b1;
    ioctl_download = 1'b0;
    step();
    chk("t7_rst_wr", ddr_wr, 0);
    chk("t7_rst_waitreq", ioctl_waitReq, 0);
    chk("t7_rst_mask", ddr_mask, 8'h00);
    reset = 1'b0;
    ddr_waitReq = 1'b0;
    step();
    chk("t7_no_done", done, 0);
    ioctl_download = 1'b1;
    step();
    word(27'h10, 16'h1010);
    word(27'h12, 16'h1212);
    word(27'h14, 16'h1414);
    word(27'h16, 16'h1616);
    chk("t7_clean_wr", ddr_wr, 1);
    chk("t7_clean_addr", ddr_addr, 32'h3000_0010);
    chk("t7_clean_din", ddr_din, 64'h1616_1414_1212_1010);
    chk("t7_clean_mask", ddr_mask, 8'hFF);
    step();
    chk("t7_clean_wr_low", ddr_wr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ioctl_ddr_writer.md
Name: ioctl_ddr_writer

Overview:
- Packs ROM-download words from the HPS ioctl interface into 64-bit DDR writes with per-byte masks.
- Sits directly downstream of hps_io ioctl outputs and upstream of the DDR arbiter port, in the clk_sys domain.
- Throttles the HPS through ioctl_waitReq while a DDR write is pending.
- Signals completion so ROM consumers can leave reset.

Parameters:
- ADDR_WIDTH, 27, ioctl byte-address width.
- DDR_ADDR_WIDTH, 32, DDR byte-address width.
- BASE_ADDR, 32'h3000_0000, DDR byte address that ioctl address 0 maps to.
- INDEX, 8'd0, ioctl_index value accepted; all other indices are ignored.

Ports:
- clock  in  1  clk_sys.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window, level.
- ioctl_wr  in  1  word strobe, one cycle per word.
- ioctl_index  in  8  download target index.
- ioctl_addr  in  ADDR_WIDTH  byte address of the word; bit 0 is always 0.
- ioctl_dout  in  16  data word, already byte-swapped upstream.
- ioctl_waitReq  out  1  stall request to HPS.
- ddr_wr  out  1  write request.
- ddr_addr  out  DDR_ADDR_WIDTH  8-byte-aligned byte address.
- ddr_din  out  64  write data.
- ddr_mask  out  8  byte enables.
- ddr_burstLength  out  8  constant 1.
- ddr_waitReq  in  1  DDR busy.
- done  out  1  one-cycle pulse at end of download.

Behaviour:
- Reset values: ioctl_waitReq=0, ddr_wr=0, ddr_addr=0, ddr_din=0, ddr_mask=0, done=0. Line buffer is cleared and state is IDLE. Reset wins over every other event; a write in progress is abandoned and ddr_wr=0 the next cycle.
- Accepted word: ioctl_wr=1, ioctl_download=1 and ioctl_index==INDEX. Others are ignored with no state change.
- Line tag: ioctl_addr[ADDR_WIDTH-1:3]. Lane k=ioctl_addr[2:1]; data goes to din[16k+15:16k] and sets mask[2k+1:2k].
- States: IDLE, FILL, WRITE, FINISH.
- IDLE:
  - Accepted word -> load lane, latch tag, go to FILL.
  - Falling edge of ioctl_download -> FINISH.
- FILL:
  - Accepted word with the same tag -> merge the lane. A repeated lane overwrites the data; the mask stays set.
  - If the mask becomes 8'hFF -> WRITE.
  - Accepted word with a different tag -> store it in a pending register (data, lane, tag) and go to WRITE with the current line.
  - Falling edge of ioctl_download -> WRITE with the flush flag set.
- WRITE:
  - ddr_wr=1. ddr_addr = BASE_ADDR + {tag,3'b000}, truncated to DDR_ADDR_WIDTH. ddr_din and ddr_mask come from the buffer.
  - Outputs hold stable while ddr_waitReq=1.
  - In the cycle where ddr_waitReq=0, the write is accepted. Next cycle: ddr_wr=0 and the buffer clears.
  - Exit: if pending is valid, load it into the buffer and go to FILL. Else if the flush flag is set, go to FINISH. Else go to IDLE.
- FINISH: done=1 for exactly one cycle, then IDLE.
- ioctl_waitReq is registered:
  - It rises the cycle after the transition into WRITE and stays high through WRITE.
  - It falls in the same cycle ddr_wr falls.
- Upstream contract: HPS issues no ioctl_wr while ioctl_waitReq=1. The bench asserts this; behaviour on violation is undefined.
- Latency: from the 4th-word strobe to ddr_wr high is 1 cycle.
- The download edge is detected from a registered copy of ioctl_download.
- Simultaneous download fall and accepted word: the word is merged first, then the line is flushed.
- Address wrap: the addition is modulo 2^DDR_ADDR_WIDTH.
- ddr_burstLength is always 8'd1.

Decomposition:
- Shared package `ddr_pkg`:
  - DDR_DATA_WIDTH=64, DDR_MASK_WIDTH=8.
  - State enum ioctl_wr_state_t.
  - Lane-to-mask function lane_mask(k).
- One sub-module, `ddr_line_buffer`: a 64-bit data/mask accumulator with merge, clear and load-pending controls. The FSM stays in the top.

Test Plan:
- Four words 1111,2222,3333,4444 at addr 0,2,4,6 -> one write: ddr_addr=3000_0000, ddr_din=4444_3333_2222_1111, mask=FF; ddr_wr high 1 cycle after 4th strobe.
- Words AAAA@8, BBBB@A, then CCCC@20 -> write addr 3000_0008 with din[31:0]=BBBB_AAAA and mask=0F, then CCCC buffered in lane 0 of tag 4.
- Full line with ddr_waitReq held high for 5 cycles -> ddr_wr, addr, din, mask stable for 6 cycles. ioctl_waitReq high throughout and low the cycle after acceptance.
- Single word 5A5A@E then ioctl_download falls -> write addr 3000_0008, mask=C0, din[63:48]=5A5A, then done pulse exactly 1 cycle. A download with no words gives a done pulse and no write.
- ioctl_index=1 strobes -> no ddr_wr, buffer unchanged. Reset asserted during WRITE with waitReq=1 -> ddr_wr=0 and ioctl_waitReq=0 next cycle; the next download starts clean.
